axi_mem_slave: RTL and testbench
================================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter MEM_AWIDTH, default 10, log2 of memory depth in AXI data words.
REQ-002 SHALL have parameter AXI_LEN_WIDTH, default 8, width of burst length fields.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 32, byte address width.
REQ-004 SHALL have parameter AXI_DATA_WIDTH, default 256, data width (power of two, >=8).
REQ-005 SHALL have port clk  in  1  sole clock.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port axi_awaddr  in  AXI_ADDR_WIDTH  write burst start byte address.
REQ-008 SHALL have port axi_awlen  in  AXI_LEN_WIDTH  write beats minus one.
REQ-009 SHALL have port axi_awvalid/axi_awready  in/out  1 each  AW handshake.
REQ-010 SHALL have port axi_wdata  in  AXI_DATA_WIDTH  write beat data.
REQ-011 SHALL have port axi_wstrb  in  AXI_DATA_WIDTH/8  byte enables.
REQ-012 SHALL have port axi_wlast  in  1  final write beat marker.
REQ-013 SHALL have port axi_wvalid/axi_wready  in/out  1 each  W handshake.
REQ-014 SHALL have port axi_bresp  out  2  write response.
REQ-015 SHALL have port axi_bvalid/axi_bready  out/in  1 each  B handshake.
REQ-016 SHALL have port axi_araddr  in  AXI_ADDR_WIDTH  read burst start byte address.
REQ-017 SHALL have port axi_arlen  in  AXI_LEN_WIDTH  read beats minus one.
REQ-018 SHALL have port axi_arvalid/axi_arready  in/out  1 each  AR handshake.
REQ-019 SHALL have port axi_rdata  out  AXI_DATA_WIDTH  read beat data.
REQ-020 SHALL have port axi_rresp  out  2  read response, constant 2'b00.
REQ-021 SHALL have port axi_rlast  out  1  final read beat marker.
REQ-022 SHALL have port axi_rvalid/axi_rready  out/in  1 each  R handshake.

Function
REQ-023 SHALL hold 2^MEM_AWIDTH words; word index = addr[LSB +: MEM_AWIDTH], LSB = log2(AXI_DATA_WIDTH/8); index increments per beat (INCR only) and wraps modulo depth.
REQ-024 Write FSM SHALL be W_IDLE (awready=1) -> W_DATA on AW handshake (latch index, len) -> W_RESP after beat len+1 -> W_IDLE on B handshake; wready=1 only in W_DATA.
REQ-025 Each W handshake SHALL write only bytes with wstrb=1; all-zero wstrb writes nothing but counts as a beat.
REQ-026 bresp SHALL be 2'b10 (SLVERR) if wlast disagrees with beat count on any beat, else 2'b00; burst still ends on beat len+1, regardless of wlast.
REQ-027 Read FSM SHALL be R_IDLE (arready=1) -> R_FETCH (one synchronous RAM read) -> R_DATA; first rvalid exactly 2 cycles after AR handshake.
REQ-028 In R_DATA, rdata/rlast SHALL stay stable while rvalid&!rready; after each R handshake next beat is valid the next cycle (full throughput with rready=1); rlast=1 on beat len+1; R_IDLE after that handshake.
REQ-029 Read and write FSMs SHALL run concurrently; same-cycle write and read to one word SHALL return old data.
REQ-030 awlen=0/arlen=0 SHALL produce single-beat bursts; maximum len 2^AXI_LEN_WIDTH-1 SHALL complete without counter overflow.

Reset
REQ-031 rst low SHALL immediately force W_IDLE/R_IDLE, awready=arready=1 after release, wready=bvalid=rvalid=rlast=0, bresp=0, rdata=0; memory contents undefined; in-flight bursts abandoned.

Configuration
REQ-032 With AXI_MEM_SLAVE_STALL_EN defined, a 16-bit LFSR (seed 16'hACE1) SHALL gate wready and rvalid low on cycles where LFSR[0]=0, still honoring REQ-028 stability; without it, no stalls are inserted.

Structure
REQ-033 Response codes (OKAY, SLVERR), FSM state encodings and LFSR seed SHALL live in shared package axi_pkg.
REQ-034 Memory SHALL be sub-module axi_mem_ram (one byte-enabled write port, one synchronous read port).

Verification
REQ-035 AW addr=0x40, len=3, four W beats 0xA..0xD, wstrb all ones -> bvalid after 4th beat, bresp=0.
REQ-036 AR addr=0x40, len=3, rready=1 -> rdata 0xA,0xB,0xC,0xD on consecutive cycles, rvalid 2 cycles after AR, rlast on 4th.
REQ-037 Write len=1 with wlast on beat 0 -> bresp=2'b10, FSM back to W_IDLE after B handshake.
REQ-038 rready toggled 1/0 during len=7 read -> all 8 beats delivered in order, rdata stable while stalled.
REQ-039 rst asserted mid write burst (beat 2 of 4) -> wready=0 immediately; after release, new AW accepted.
REQ-040 Write at last word index, len=1 -> second beat lands at index 0 (wrap), read-back confirms.

Source files
------------

// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared constants for the AXI memory slave: response codes, write/read FSM
// state encodings, and the stall LFSR seed plus its next-state function.
// No ports.
// -----------------------------------------------------------------------------
package axi_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] i_state);
    return {i_state[0] ^ i_state[2] ^ i_state[3] ^ i_state[5], i_state[15:1]};
  endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// -----------------------------------------------------------------------------
// axi_mem_slave_if
// AXI4 subset bus (AW/W/B/AR/R, INCR bursts only) between a master and
// axi_mem_slave.
//   slave  modport : address/data/valid/ready-from-master as inputs,
//                    ready/response/read data as outputs.
//   master modport : the mirror image.
// -----------------------------------------------------------------------------
interface axi_mem_slave_if #(
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256
);

  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr;
  logic [AXI_LEN_WIDTH-1:0]    axi_awlen;
  logic                        axi_awvalid;
  logic                        axi_awready;

  logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                        axi_wlast;
  logic                        axi_wvalid;
  logic                        axi_wready;

  logic [1:0]                  axi_bresp;
  logic                        axi_bvalid;
  logic                        axi_bready;

  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr;
  logic [AXI_LEN_WIDTH-1:0]    axi_arlen;
  logic                        axi_arvalid;
  logic                        axi_arready;

  logic [AXI_DATA_WIDTH-1:0]   axi_rdata;
  logic [1:0]                  axi_rresp;
  logic                        axi_rlast;
  logic                        axi_rvalid;
  logic                        axi_rready;

  modport slave (
    input  axi_awaddr, axi_awlen, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arlen, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );

  modport master (
    output axi_awaddr, axi_awlen, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arlen, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );

endinterface

// File: rtl/axi_mem_ram.sv
// -----------------------------------------------------------------------------
// axi_mem_ram
// 2^AWIDTH x DWIDTH memory with one byte-enabled write port and one
// synchronous read port. Read-before-write: a read and write to the same word
// on the same edge returns the old contents. The read register holds its value
// while i_re is low, which is what keeps R-channel data stable under backpressure.
//   clk, rst      : clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata/i_wbe : write port
//   i_re/i_raddr  : read request
//   o_rdata       : registered read data
// -----------------------------------------------------------------------------
module axi_mem_ram #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [AWIDTH-1:0]   i_waddr,
  input  logic [DWIDTH-1:0]   i_wdata,
  input  logic [DWIDTH/8-1:0] i_wbe,
  input  logic                i_re,
  input  logic [AWIDTH-1:0]   i_raddr,
  output logic [DWIDTH-1:0]   o_rdata
);

  localparam int NBYTES = DWIDTH / 8;

  logic [DWIDTH-1:0] r_mem [2**AWIDTH];
  logic [DWIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_mem_slave.sv
// -----------------------------------------------------------------------------
// axi_mem_slave
// AXI4 memory slave (INCR bursts) backed by axi_mem_ram. Independent write and
// read FSMs run concurrently; the word index wraps modulo memory depth.
//   clk   : sole clock
//   rst   : asynchronous active-low reset
//   s_axi : axi_mem_slave_if.slave bus port
// Build option: define AXI_MEM_SLAVE_STALL_EN to insert pseudo-random stalls
// on wready/rvalid from a 16-bit LFSR; otherwise no stalls are inserted.
//
// Write FSM
//   state   | meaning
//   W_IDLE  | awready=1, waiting for a burst address
//   W_DATA  | wready=1, accepting beats until len+1 have been taken
//   W_RESP  | bvalid=1, waiting for bready
// Read FSM
//   state   | meaning
//   R_IDLE  | arready=1, waiting for a burst address
//   R_FETCH | first RAM read in flight
//   R_DATA  | rvalid=1, one beat presented per R handshake
// -----------------------------------------------------------------------------
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int MEM_AWIDTH     = 10,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256
) (
  input logic             clk,
  input logic             rst,
  axi_mem_slave_if.slave  s_axi
);

  localparam int LSB = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [AXI_LEN_WIDTH-1:0] LEN_ONE = {{(AXI_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MEM_AWIDTH-1:0]    IDX_ONE = {{(MEM_AWIDTH-1){1'b0}}, 1'b1};

  logic w_go;

`ifdef AXI_MEM_SLAVE_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_go = r_lfsr[0];
`else
  assign w_go = 1'b1;
`endif

  // Only the word-index bits of the addresses matter to this slave.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{s_axi.axi_awaddr, s_axi.axi_araddr};

  // ---------------------------------------------------------------- write
  logic [1:0]               r_wstate;
  logic [MEM_AWIDTH-1:0]    r_widx;
  logic [AXI_LEN_WIDTH-1:0] r_wrem;
  logic                     r_werr;
  axi_resp_t                r_bresp;
  logic                     w_aw_hs;
  logic                     w_w_hs;
  logic                     w_b_hs;
  logic                     w_wlast_exp;
  logic                     w_wbeat_err;

  assign s_axi.axi_awready = (r_wstate == W_IDLE);
  assign s_axi.axi_wready  = (r_wstate == W_DATA) & w_go;
  assign s_axi.axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi.axi_bresp   = r_bresp;

  assign w_aw_hs     = s_axi.axi_awvalid & s_axi.axi_awready;
  assign w_w_hs      = s_axi.axi_wvalid & s_axi.axi_wready;
  assign w_b_hs      = s_axi.axi_bvalid & s_axi.axi_bready;
  assign w_wlast_exp = (r_wrem == '0);
  assign w_wbeat_err = (s_axi.axi_wlast != w_wlast_exp);

  // r_wrem counts remaining beats down; the burst ends on the beat where it
  // is zero, whatever wlast says, so len = all ones cannot overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_widx   <= '0;
      r_wrem   <= '0;
      r_werr   <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_widx   <= s_axi.axi_awaddr[LSB +: MEM_AWIDTH];
            r_wrem   <= s_axi.axi_awlen;
            r_werr   <= 1'b0;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            if (w_wlast_exp) begin
              r_bresp  <= (r_werr | w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end else begin
              r_werr <= r_werr | w_wbeat_err;
              r_wrem <= r_wrem - LEN_ONE;
              r_widx <= r_widx + IDX_ONE;
            end
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- read
  logic [1:0]               r_rstate;
  logic [MEM_AWIDTH-1:0]    r_ridx;
  logic [AXI_LEN_WIDTH-1:0] r_rrem;
  logic                     w_ar_hs;
  logic                     w_r_hs;
  logic                     w_ram_re;
  logic [MEM_AWIDTH-1:0]    w_ram_raddr;
  logic [AXI_DATA_WIDTH-1:0] w_ram_rdata;

  assign s_axi.axi_arready = (r_rstate == R_IDLE);
  assign s_axi.axi_rvalid  = (r_rstate == R_DATA) & w_go;
  assign s_axi.axi_rlast   = (r_rstate == R_DATA) & (r_rrem == '0);
  assign s_axi.axi_rdata   = w_ram_rdata;
  assign s_axi.axi_rresp   = RESP_OKAY;

  assign w_ar_hs = s_axi.axi_arvalid & s_axi.axi_arready;
  assign w_r_hs  = s_axi.axi_rvalid & s_axi.axi_rready;

  // r_ridx is the index of the beat on the bus; the next beat is prefetched
  // on the handshake edge so it appears the following cycle.
  assign w_ram_re    = (r_rstate == R_FETCH) | (w_r_hs & (r_rrem != '0));
  assign w_ram_raddr = (r_rstate == R_FETCH) ? r_ridx : r_ridx + IDX_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_ridx   <= '0;
      r_rrem   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_ridx   <= s_axi.axi_araddr[LSB +: MEM_AWIDTH];
            r_rrem   <= s_axi.axi_arlen;
            r_rstate <= R_FETCH;
          end
        end
        R_FETCH: r_rstate <= R_DATA;
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rrem == '0) begin
              r_rstate <= R_IDLE;
            end else begin
              r_rrem <= r_rrem - LEN_ONE;
              r_ridx <= r_ridx + IDX_ONE;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  axi_mem_ram #(
    .AWIDTH (MEM_AWIDTH),
    .DWIDTH (AXI_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_w_hs),
    .i_waddr (r_widx),
    .i_wdata (s_axi.axi_wdata),
    .i_wbe   (s_axi.axi_wstrb),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_axi_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_slave
// Self-checking bench for axi_mem_slave. Bursts are driven and sampled on the
// falling clock edge; expected read data comes from a byte-granular array model
// of the memory that records which bytes have been written since reset.
// -----------------------------------------------------------------------------
module tb_axi_mem_slave;

  localparam int DW    = 256;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_mem_slave_if #(.AXI_LEN_WIDTH(8), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(DW)) bus ();

  axi_mem_slave #(
    .MEM_AWIDTH     (10),
    .AXI_LEN_WIDTH  (8),
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (DW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [NB-1:0] model_ok  [DEPTH];
  logic [DW-1:0] tb_wdata  [256];
  logic [NB-1:0] tb_wstrb  [256];

  function automatic logic [DW-1:0] byte_mask(input logic [NB-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) if (m[b]) r[b*8 +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(a[14:5]);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_ok[i] = '0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input int len, input int bad_beat,
                             input int bdelay, input string tag);
    int g;
    int idx;
    logic exp_err;
    exp_err = 1'b0;
    bus.axi_awaddr  = addr;
    bus.axi_awlen   = 8'(len);
    bus.axi_awvalid = 1'b1;
    g = 0;
    while (bus.axi_awready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    checks++;
    if (g >= 100) begin
      failures++; $display("FAIL %s_aw_timeout awready=%b exp=1", tag, bus.axi_awready);
      bus.axi_awvalid = 1'b0; return;
    end
    @(negedge clk);
    bus.axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == bad_beat) exp_err = 1'b1;
      bus.axi_wdata  = tb_wdata[i];
      bus.axi_wstrb  = tb_wstrb[i];
      bus.axi_wlast  = (i == len) ^ (i == bad_beat);
      bus.axi_wvalid = 1'b1;
      g = 0;
      while (bus.axi_wready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
      checks++;
      if (g >= 100) begin
        failures++; $display("FAIL %s_w_timeout beat=%0d wready=%b exp=1", tag, i, bus.axi_wready);
        bus.axi_wvalid = 1'b0; return;
      end
      idx = (word_of(addr) + i) % DEPTH;
      for (int b = 0; b < NB; b++) begin
        if (tb_wstrb[i][b]) begin
          model_mem[idx][b*8 +: 8] = tb_wdata[i][b*8 +: 8];
          model_ok[idx][b] = 1'b1;
        end
      end
      @(negedge clk);
    end
    bus.axi_wvalid = 1'b0;
    bus.axi_wlast  = 1'b0;
    repeat (bdelay) @(negedge clk);
    checks++;
    if ({bus.axi_bvalid, bus.axi_wready} !== 2'b10) begin
      failures++; $display("FAIL %s_bvalid {bvalid,wready}=%b exp=10", tag, {bus.axi_bvalid, bus.axi_wready});
    end
    bus.axi_bready = 1'b1;
    checks++;
    if (bus.axi_bresp !== (exp_err ? 2'b10 : 2'b00)) begin
      failures++; $display("FAIL %s_bresp got=%b exp=%b", tag, bus.axi_bresp, exp_err ? 2'b10 : 2'b00);
    end
    @(negedge clk);
    bus.axi_bready = 1'b0;
    checks++;
    if ({bus.axi_bvalid, bus.axi_awready} !== 2'b01) begin
      failures++; $display("FAIL %s_widle {bvalid,awready}=%b exp=01", tag, {bus.axi_bvalid, bus.axi_awready});
    end
  endtask

  // mode 0: rready held high, 1: rready toggles starting low, 2: random rready
  task automatic read_burst(input logic [31:0] addr, input int len, input int mode, input string tag);
    int g, lat, beat, cyc, idx;
    logic prev_stall, prev_l, rr;
    logic [DW-1:0] prev_d, m;
    bus.axi_araddr  = addr;
    bus.axi_arlen   = 8'(len);
    bus.axi_arvalid = 1'b1;
    g = 0;
    while (bus.axi_arready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    checks++;
    if (g >= 100) begin
      failures++; $display("FAIL %s_ar_timeout arready=%b exp=1", tag, bus.axi_arready);
      bus.axi_arvalid = 1'b0; return;
    end
    @(negedge clk);
    bus.axi_arvalid = 1'b0;
    lat = 1;
    while (bus.axi_rvalid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (lat >= 100) begin
      failures++; $display("FAIL %s_r_timeout rvalid=%b exp=1", tag, bus.axi_rvalid); return;
    end
`ifndef AXI_MEM_SLAVE_STALL_EN
    checks++;
    if (lat != 2) begin
      failures++; $display("FAIL %s_latency got=%0d exp=2", tag, lat);
    end
`endif
    beat = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    rr = (mode == 1) ? 1'b0 : 1'b1;
    while (beat <= len && cyc < 4000) begin
      bus.axi_rready = rr;
      if (prev_stall) begin
        checks++;
        if ({bus.axi_rdata, bus.axi_rlast} !== {prev_d, prev_l}) begin
          failures++; $display("FAIL %s_stable beat=%0d rdata=%h rlast=%b exp rdata=%h rlast=%b",
                               tag, beat, bus.axi_rdata, bus.axi_rlast, prev_d, prev_l);
        end
      end
      if (bus.axi_rvalid === 1'b1 && rr) begin
        idx = (word_of(addr) + beat) % DEPTH;
        m = byte_mask(model_ok[idx]);
        checks++;
        if ((bus.axi_rdata & m) !== (model_mem[idx] & m)) begin
          failures++; $display("FAIL %s_rdata beat=%0d got=%h exp=%h", tag, beat,
                               bus.axi_rdata & m, model_mem[idx] & m);
        end
        checks++;
        if (bus.axi_rlast !== (beat == len)) begin
          failures++; $display("FAIL %s_rlast beat=%0d got=%b exp=%b", tag, beat, bus.axi_rlast, beat == len);
        end
        beat++;
      end
      prev_stall = (bus.axi_rvalid === 1'b1) && !rr;
      prev_d = bus.axi_rdata;
      prev_l = bus.axi_rlast;
      @(negedge clk);
      cyc++;
      if (mode == 1) rr = ~rr;
      else if (mode == 2) rr = 1'($urandom_range(0, 1));
    end
    bus.axi_rready = 1'b0;
    checks++;
    if (beat <= len) begin
      failures++; $display("FAIL %s_beats got=%0d exp=%0d", tag, beat, len + 1);
    end
`ifndef AXI_MEM_SLAVE_STALL_EN
    if (mode == 0) begin
      checks++;
      if (cyc != len + 1) begin
        failures++; $display("FAIL %s_throughput cycles=%0d exp=%0d", tag, cyc, len + 1);
      end
    end
`endif
    checks++;
    if ({bus.axi_rvalid, bus.axi_arready} !== 2'b01) begin
      failures++; $display("FAIL %s_ridle {rvalid,arready}=%b exp=01", tag, {bus.axi_rvalid, bus.axi_arready});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.axi_wready, bus.axi_bvalid, bus.axi_rvalid, bus.axi_rlast, bus.axi_bresp} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl {wready,bvalid,rvalid,rlast,bresp}=%b exp=000000",
                           {bus.axi_wready, bus.axi_bvalid, bus.axi_rvalid, bus.axi_rlast, bus.axi_bresp});
    end
    checks++;
    if (bus.axi_rdata !== '0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", bus.axi_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.axi_awready, bus.axi_arready, bus.axi_rresp} !== 4'b1100) begin
      failures++; $display("FAIL reset_ready {awready,arready,rresp}=%b exp=1100",
                           {bus.axi_awready, bus.axi_arready, bus.axi_rresp});
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      tb_wdata[i] = DW'(10 + i);
      tb_wstrb[i] = '1;
    end
    write_burst(32'h40, 3, -1, 0, "basic_wr");
    read_burst(32'h40, 3, 0, "basic_rd");
  endtask

  task automatic test_wlast_err();
    for (int i = 0; i < 3; i++) begin tb_wdata[i] = rand_word(); tb_wstrb[i] = '1; end
    write_burst(32'h200, 1, 0, 1, "wlast_early");
    write_burst(32'h300, 2, 2, 0, "wlast_missing");
    read_burst(32'h300, 2, 0, "wlast_rd");
  endtask

  task automatic test_rready_toggle();
    for (int i = 0; i < 8; i++) begin tb_wdata[i] = rand_word(); tb_wstrb[i] = '1; end
    write_burst(32'h1000, 7, -1, 0, "toggle_wr");
    read_burst(32'h1000, 7, 1, "toggle_rd");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 2; i++) begin tb_wdata[i] = rand_word(); tb_wstrb[i] = '1; end
    write_burst(32'h7FE0, 1, -1, 0, "wrap_wr");
    read_burst(32'h7FE0, 1, 0, "wrap_rd");
    read_burst(32'h0, 0, 0, "wrap_idx0");
  endtask

  task automatic test_concurrent();
    logic [DW-1:0] oldw, neww;
    int g;
    oldw = rand_word();
    neww = rand_word();
    tb_wdata[0] = oldw; tb_wstrb[0] = '1;
    write_burst(32'h0C80, 0, -1, 0, "conc_pre");
    bus.axi_awaddr = 32'h0C80; bus.axi_awlen = 8'd0; bus.axi_awvalid = 1'b1;
    g = 0;
    while (bus.axi_awready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    @(negedge clk);
    bus.axi_awvalid = 1'b0;
    bus.axi_araddr = 32'h0C80; bus.axi_arlen = 8'd0; bus.axi_arvalid = 1'b1;
    checks++;
    if (bus.axi_arready !== 1'b1) begin
      failures++; $display("FAIL conc_arready got=%b exp=1", bus.axi_arready);
    end
    @(negedge clk);
    bus.axi_arvalid = 1'b0;
    bus.axi_wdata = neww; bus.axi_wstrb = '1; bus.axi_wlast = 1'b1; bus.axi_wvalid = 1'b1;
    g = 0;
    while (bus.axi_wready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    @(negedge clk);
    bus.axi_wvalid = 1'b0; bus.axi_wlast = 1'b0;
    g = 0;
    while (bus.axi_rvalid !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    checks++;
    if (bus.axi_rdata !== oldw) begin
      failures++; $display("FAIL conc_old_data got=%h exp=%h", bus.axi_rdata, oldw);
    end
    bus.axi_rready = 1'b1;
    @(negedge clk);
    bus.axi_rready = 1'b0;
    g = 0;
    while (bus.axi_bvalid !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    checks++;
    if ({bus.axi_bvalid, bus.axi_bresp} !== 3'b100) begin
      failures++; $display("FAIL conc_bresp {bvalid,bresp}=%b exp=100", {bus.axi_bvalid, bus.axi_bresp});
    end
    bus.axi_bready = 1'b1;
    @(negedge clk);
    bus.axi_bready = 1'b0;
    model_mem[100] = neww;
    model_ok[100]  = '1;
    read_burst(32'h0C80, 0, 0, "conc_new");
  endtask

  task automatic test_reset_mid();
    int g;
    for (int i = 0; i < 4; i++) begin tb_wdata[i] = rand_word(); tb_wstrb[i] = '1; end
    bus.axi_awaddr = 32'h2000; bus.axi_awlen = 8'd3; bus.axi_awvalid = 1'b1;
    g = 0;
    while (bus.axi_awready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    @(negedge clk);
    bus.axi_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.axi_wdata = tb_wdata[i]; bus.axi_wstrb = '1; bus.axi_wlast = 1'b0; bus.axi_wvalid = 1'b1;
      g = 0;
      while (bus.axi_wready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
      if (i < 2) @(negedge clk);
    end
    checks++;
    if (bus.axi_wready !== 1'b1) begin
      failures++; $display("FAIL rstmid_beat2 wready=%b exp=1", bus.axi_wready);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.axi_wready, bus.axi_bvalid, bus.axi_rvalid, bus.axi_rlast, bus.axi_bresp} !== 6'b0) begin
      failures++; $display("FAIL rstmid_async {wready,bvalid,rvalid,rlast,bresp}=%b exp=000000",
                           {bus.axi_wready, bus.axi_bvalid, bus.axi_rvalid, bus.axi_rlast, bus.axi_bresp});
    end
    checks++;
    if (bus.axi_rdata !== '0) begin
      failures++; $display("FAIL rstmid_rdata got=%h exp=0", bus.axi_rdata);
    end
    @(negedge clk);
    bus.axi_wvalid = 1'b0;
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    checks++;
    if ({bus.axi_awready, bus.axi_arready, bus.axi_wready, bus.axi_bvalid} !== 4'b1100) begin
      failures++; $display("FAIL rstmid_release {awready,arready,wready,bvalid}=%b exp=1100",
                           {bus.axi_awready, bus.axi_arready, bus.axi_wready, bus.axi_bvalid});
    end
    for (int i = 0; i < 4; i++) begin tb_wdata[i] = rand_word(); tb_wstrb[i] = '1; end
    write_burst(32'h2000, 3, -1, 0, "rstmid_wr");
    read_burst(32'h2000, 3, 0, "rstmid_rd");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int len, bad, sel;
    for (int it = 0; it < 8; it++) begin
      addr = $urandom;
      len  = $urandom_range(0, 15);
      for (int i = 0; i <= len; i++) begin
        tb_wdata[i] = rand_word();
        sel = $urandom_range(0, 7);
        tb_wstrb[i] = (sel == 0) ? '0 : (sel < 3) ? NB'($urandom) : '1;
      end
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      write_burst(addr, len, bad, $urandom_range(0, 3), "rand_wr");
      read_burst(addr, len, 2, "rand_rd");
    end
  endtask

  task automatic test_max_len();
    logic [31:0] addr;
    addr = $urandom;
    for (int i = 0; i < 256; i++) begin tb_wdata[i] = rand_word(); tb_wstrb[i] = '1; end
    write_burst(addr, 255, -1, 0, "max_wr");
    read_burst(addr, 255, 0, "max_rd");
  endtask

  initial begin
    bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awvalid = 1'b0;
    bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wlast = 1'b0; bus.axi_wvalid = 1'b0;
    bus.axi_bready = 1'b0;
    bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arvalid = 1'b0;
    bus.axi_rready = 1'b0;
    clear_model();
    test_reset();
    test_basic();
    test_wlast_err();
    test_rready_toggle();
    test_wrap();
    test_concurrent();
    test_reset_mid();
    test_random();
    test_max_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
